uart_boot_loader: RTL and testbench

- Upstream stage of the CPU: receives a program image over a UART line and writes it word-by-word into instruction/data memory before the core runs.
- Holds the CPU in reset while loading, then releases it.
- Contains an 8N1 UART receiver, a little-endian word assembler and a load sequencer.
- Output feeds the memory controller's load/write port and the CPU reset.

---
 rtl/uart_boot_loader.sv | 170 +++++++++++++++++
 tb/tb_uart_boot_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// UART boot loader: 8N1 receiver feeding a little-endian word assembler that
// writes a length-prefixed program image into memory while holding the CPU in reset.
module uart_boot_loader #(
    parameter int CLKS_PER_BIT = 104,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {LD_LEN0, LD_LEN1, LD_DATA, LD_WRITE, LD_DONE} ld_state_t;

    rx_state_t   rx_state;
    logic        rx_meta;
    logic        rx_sync;
    logic        rx_prev;
    logic [CW-1:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  rx_shift;
    logic        byte_valid;

    ld_state_t   ld_state;
    logic [15:0] count;
    logic [1:0]  byte_idx;
    logic [15:0] word_idx;
    logic [31:0] word;

    // Receiver: start edge detection, mid-bit sampling of the synchronised line.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            rx_state   <= RX_IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        bit_cnt  <= '0;
                    end
                end
                RX_START: begin
                    if (bit_cnt == HALF_LAST) begin
                        bit_cnt <= '0;
                        if (!rx_sync) begin
                            rx_state <= RX_DATA;
                            bit_idx  <= '0;
                        end else begin
                            rx_state <= RX_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt  <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (bit_idx == 3'd7)
                            rx_state <= RX_STOP;
                        else
                            bit_idx <= bit_idx + 3'd1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt  <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync)
                            byte_valid <= 1'b1;
                        else
                            err <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Load sequencer: 16-bit little-endian length, then that many 32-bit words.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_state  <= LD_LEN0;
            count     <= '0;
            byte_idx  <= '0;
            word_idx  <= '0;
            word      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rst   <= 1'b1;
            done      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (ld_state)
                LD_LEN0: begin
                    if (byte_valid) begin
                        count[7:0] <= rx_shift;
                        ld_state   <= LD_LEN1;
                    end
                end
                LD_LEN1: begin
                    if (byte_valid) begin
                        count[15:8] <= rx_shift;
                        if ({rx_shift, count[7:0]} == 16'd0) begin
                            ld_state <= LD_DONE;
                            cpu_rst  <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            ld_state <= LD_DATA;
                            byte_idx <= '0;
                            word_idx <= '0;
                        end
                    end
                end
                LD_DATA: begin
                    if (byte_valid) begin
                        word     <= {rx_shift, word[31:8]};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            ld_state  <= LD_WRITE;
                            mem_we    <= 1'b1;
                            mem_addr  <= word_idx[ADDR_WIDTH-1:0];
                            mem_wdata <= {rx_shift, word[31:8]};
                        end
                    end
                end
                LD_WRITE: begin
                    word_idx <= word_idx + 16'd1;
                    if (word_idx + 16'd1 == count) begin
                        ld_state <= LD_DONE;
                        cpu_rst  <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        ld_state <= LD_DATA;
                    end
                end
                LD_DONE: ;
                default: ld_state <= LD_LEN0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: serialises images over rx and compares
// the observed memory writes against writes derived directly from the byte stream.
module tb_uart_boot_loader;

    localparam int CPB = 4;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx  = 1'b1;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_rst;
    logic          done;
    logic          err;

    uart_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst(cpu_rst), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_checks = 0;

    // write monitor
    int          cyc = 0;
    int          we_addr_q[$];
    logic [31:0] we_data_q[$];
    int          last_we_cyc = -1;
    int          done_cyc = -1;
    int          we_double = 0;
    int          rd_bad = 0;
    logic        we_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (mem_we) begin
            we_addr_q.push_back(int'(mem_addr));
            we_data_q.push_back(mem_wdata);
            last_we_cyc = cyc;
            if (we_prev) we_double++;
        end
        we_prev = mem_we;
        if (done && done_cyc < 0) done_cyc = cyc;
        if (cpu_rst == done) rd_bad++;
    end

    logic [7:0] data_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_mon();
        we_addr_q.delete();
        we_data_q.delete();
        last_we_cyc = -1;
        done_cyc = -1;
        we_double = 0;
        rd_bad = 0;
        we_prev = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_mon();
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        send_bit(1'b1);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, 64'(done), 64'(1));
        repeat (3) @(negedge clk);
    endtask

    task automatic fill_random(input int words);
        data_q.delete();
        for (int i = 0; i < 4 * words; i++) data_q.push_back(8'($urandom_range(0, 255)));
    endtask

    // Expected word i is bytes 4i..4i+3 of the payload, least significant first.
    function automatic logic [31:0] exp_word(input int i);
        return 32'(data_q[4*i]) + (32'(data_q[4*i+1]) << 8)
             + (32'(data_q[4*i+2]) << 16) + (32'(data_q[4*i+3]) << 24);
    endfunction

    task automatic run_load(input string name, input int cnt, input bit with_rst);
        if (with_rst) do_reset();
        send_byte(8'(cnt), 1'b1);
        send_byte(8'(cnt >> 8), 1'b1);
        foreach (data_q[i]) send_byte(data_q[i], 1'b1);
        wait_done(name);
        check({name, "_nwrites"}, 64'(we_addr_q.size()), 64'(cnt));
        for (int i = 0; i < cnt && i < we_addr_q.size(); i++) begin
            check($sformatf("%s_addr%0d", name, i), 64'(we_addr_q[i]), 64'(i % (1 << AW)));
            check($sformatf("%s_data%0d", name, i), 64'(we_data_q[i]), 64'(exp_word(i)));
        end
        if (cnt > 0) begin
            check({name, "_done_lat"}, 64'(done_cyc - last_we_cyc), 64'(1));
            check({name, "_addr_hold"}, 64'(mem_addr), 64'((cnt - 1) % (1 << AW)));
            check({name, "_data_hold"}, 64'(mem_wdata), 64'(exp_word(cnt - 1)));
        end
        check({name, "_we_pulse"}, 64'(we_double), 64'(0));
        check({name, "_rst_done"}, 64'(rd_bad), 64'(0));
        check({name, "_cpu_rst"}, 64'(cpu_rst), 64'(0));
    endtask

    initial begin
        logic [7:0] b0;
        int         cnt;

        // reset state
        do_reset();
        check("rst_we", 64'(mem_we), 64'(0));
        check("rst_addr", 64'(mem_addr), 64'(0));
        check("rst_wdata", 64'(mem_wdata), 64'(0));
        check("rst_cpu_rst", 64'(cpu_rst), 64'(1));
        check("rst_done", 64'(done), 64'(0));
        check("rst_err", 64'(err), 64'(0));

        // two directed words
        data_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_load("basic", 2, 1'b1);
        check("basic_err", 64'(err), 64'(0));

        // empty image
        data_q.delete();
        run_load("zero", 0, 1'b1);
        check("zero_err", 64'(err), 64'(0));

        // random small images
        for (int t = 0; t < 2; t++) begin
            cnt = $urandom_range(1, 5);
            fill_random(cnt);
            run_load($sformatf("rand%0d", t), cnt, 1'b1);
        end

        // address wrap past memory depth
        fill_random(17);
        run_load("wrap", 17, 1'b1);

        // framing error on a payload byte
        do_reset();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'($urandom_range(0, 255)), 1'b0);
        data_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        foreach (data_q[i]) send_byte(data_q[i], 1'b1);
        wait_done("frame");
        check("frame_err", 64'(err), 64'(1));
        check("frame_nwrites", 64'(we_addr_q.size()), 64'(1));
        if (we_addr_q.size() > 0) begin
            check("frame_addr", 64'(we_addr_q[0]), 64'(0));
            check("frame_data", 64'(we_data_q[0]), 64'(32'hDDCCBBAA));
        end

        // one-clock glitch in idle, then a valid image
        do_reset();
        rx = 1'b0;
        @(posedge clk);
        #1 rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("glitch_err", 64'(err), 64'(0));
        check("glitch_nwrites", 64'(we_addr_q.size()), 64'(0));
        fill_random(1);
        run_load("glitch", 1, 1'b0);
        check("glitch_err_after", 64'(err), 64'(0));

        // reset in the middle of word 1
        do_reset();
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        b0 = 8'($urandom_range(0, 255)) | 8'h01;
        send_byte(b0, 1'b1);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
        check("mid_first_write", 64'(we_addr_q.size()), 64'(1));
        send_byte(8'($urandom_range(0, 255)), 1'b1);
        send_byte(8'($urandom_range(0, 255)), 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_we", 64'(mem_we), 64'(0));
        check("mid_rst_addr", 64'(mem_addr), 64'(0));
        check("mid_rst_wdata", 64'(mem_wdata), 64'(0));
        check("mid_rst_cpu_rst", 64'(cpu_rst), 64'(1));
        check("mid_rst_done", 64'(done), 64'(0));
        rst = 1'b0;
        clear_mon();
        fill_random(1);
        run_load("post_rst", 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
